// File: rtl/ps2_host_tx_if.sv
// Command-byte request/status bundle between a requester and the PS/2 host transmitter.
// tx_valid/tx_data are held by the requester until tx_ready; status signals come from the transmitter.
`timescale 1ns/1ps
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, err, err_code
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, err, err_code
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11 device-clocked bits, ACK check.
// One byte per accept; tx_ready only in IDLE, requests during a transfer are dropped, not queued.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int REQ_CYCLES     = 16,
    parameter int START_TIMEOUT  = 375000,
    parameter int XFER_TIMEOUT   = 50000,
    parameter int FILTER_LEN     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          PS2C,
    input  logic          PS2D,
    output logic          ps2c_low,
    output logic          ps2d_low,
    ps2_host_tx_if.slave  tx
);

    localparam int M_A  = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int M_B  = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int MAXC = (M_A > M_B) ? M_A : M_B;
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] T_MAX   = TW'(MAXC);
    localparam logic [TW-1:0] T_INH   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] T_REQ   = TW'(REQ_CYCLES - 1);
    localparam logic [TW-1:0] T_START = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] T_XFER  = TW'(XFER_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_WAIT_CLK, S_SHIFT, S_WAIT_IDLE
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic [8:0]      shift, shift_n;
    logic [3:0]      edge_cnt, edge_n;
    logic            c_low_n, d_low_n;
    logic            done_r, done_n, err_r, err_n;
    logic [1:0]      code_r, code_n;

    logic            c_s1, c_s2, d_s1, d_s2;
    logic [FILTER_LEN-1:0] c_hist;
    logic            c_filt, fall;

    // Synchronizers idle high so reset never looks like a falling clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_s1   <= 1'b1;
            c_s2   <= 1'b1;
            d_s1   <= 1'b1;
            d_s2   <= 1'b1;
            c_hist <= '1;
            c_filt <= 1'b1;
            fall   <= 1'b0;
        end else begin
            c_s1   <= PS2C;
            c_s2   <= c_s1;
            d_s1   <= PS2D;
            d_s2   <= d_s1;
            c_hist <= {c_hist[FILTER_LEN-2:0], c_s2};
            if (&c_hist)
                c_filt <= 1'b1;
            else if (~|c_hist)
                c_filt <= 1'b0;
            fall   <= c_filt & ~|c_hist;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tmr      <= '0;
            shift    <= '0;
            edge_cnt <= '0;
            ps2c_low <= 1'b0;
            ps2d_low <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            code_r   <= 2'd0;
        end else begin
            state    <= state_n;
            tmr      <= tmr_n;
            shift    <= shift_n;
            edge_cnt <= edge_n;
            ps2c_low <= c_low_n;
            ps2d_low <= d_low_n;
            done_r   <= done_n;
            err_r    <= err_n;
            code_r   <= code_n;
        end
    end

    always_comb begin
        state_n = state;
        tmr_n   = (tmr == T_MAX) ? tmr : tmr + 1'b1;
        shift_n = shift;
        edge_n  = edge_cnt;
        c_low_n = ps2c_low;
        d_low_n = ps2d_low;
        done_n  = 1'b0;
        err_n   = 1'b0;
        code_n  = code_r;
        case (state)
            S_IDLE: begin
                tmr_n   = '0;
                c_low_n = 1'b0;
                d_low_n = 1'b0;
                if (tx.tx_valid) begin
                    shift_n = {~^tx.tx_data, tx.tx_data};
                    code_n  = 2'd0;
                    c_low_n = 1'b1;
                    state_n = S_INHIBIT;
                end
            end
            S_INHIBIT: if (tmr == T_INH) begin
                tmr_n   = '0;
                d_low_n = 1'b1;
                state_n = S_REQ;
            end
            S_REQ: if (tmr == T_REQ) begin
                tmr_n   = '0;
                c_low_n = 1'b0;
                state_n = S_WAIT_CLK;
            end
            S_WAIT_CLK: begin
                if (fall) begin
                    d_low_n = ~shift[0];
                    shift_n = {1'b0, shift[8:1]};
                    edge_n  = 4'd1;
                    tmr_n   = '0;
                    state_n = S_SHIFT;
                end else if (tmr == T_START) begin
                    state_n = S_IDLE;
                    d_low_n = 1'b0;
                    err_n   = 1'b1;
                    code_n  = 2'd1;
                end
            end
            S_SHIFT: begin
                // edge_cnt holds the count before this fall: 1..8 data/parity, 9 stop, 10 ACK.
                if (fall) begin
                    edge_n = edge_cnt + 4'd1;
                    if (edge_cnt <= 4'd8) begin
                        d_low_n = ~shift[0];
                        shift_n = {1'b0, shift[8:1]};
                    end else if (edge_cnt == 4'd9) begin
                        d_low_n = 1'b0;
                    end else if (!d_s2) begin
                        state_n = S_WAIT_IDLE;
                    end else begin
                        state_n = S_IDLE;
                        d_low_n = 1'b0;
                        err_n   = 1'b1;
                        code_n  = 2'd3;
                    end
                end else if (tmr == T_XFER) begin
                    state_n = S_IDLE;
                    d_low_n = 1'b0;
                    err_n   = 1'b1;
                    code_n  = 2'd2;
                end
            end
            S_WAIT_IDLE: begin
                if (c_filt) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (tmr == T_XFER) begin
                    err_n   = 1'b1;
                    code_n  = 2'd2;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign tx.tx_ready = (state == S_IDLE);
    assign tx.busy     = (state != S_IDLE);
    assign tx.done     = done_r;
    assign tx.err      = err_r;
    assign tx.err_code = code_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a 40-cycle-period open-drain PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_c = 1'b0;
    logic dev_d = 1'b0;
    logic ps2c_low, ps2d_low;
    logic ps2c_pin, ps2d_pin;

    assign ps2c_pin = ~(ps2c_low | dev_c);
    assign ps2d_pin = ~(ps2d_low | dev_d);

    ps2_host_tx_if bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES(20),
        .REQ_CYCLES(4),
        .START_TIMEOUT(500),
        .XFER_TIMEOUT(2000),
        .FILTER_LEN(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .PS2C(ps2c_pin),
        .PS2D(ps2d_pin),
        .ps2c_low(ps2c_low),
        .ps2d_low(ps2d_low),
        .tx(bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.err) err_cnt++;
        if (bus.done && bus.err) both_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.tx_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        chk("tx_ready_after_accept", {31'd0, bus.tx_ready}, 32'd0);
    endtask

    // Device: waits for request-to-send, samples PS2D on each rising clock edge.
    task automatic dev_run(input int stop_after, input bit nack, input bit glitch,
                           input bit collide, output logic [10:0] frame, output int busy_low);
        int w;
        frame    = '1;
        busy_low = 0;
        w        = 0;
        @(negedge clk);
        while (!(!ps2c_low && ps2d_low) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) begin
            chk("rts_seen", 32'd0, 32'd1);
        end else begin
            repeat (10) @(negedge clk);
            frame[0] = ps2d_pin;
            for (int k = 1; k <= 11; k++) begin
                if (k <= stop_after) begin
                    if (k == 11 && !nack) dev_d = 1'b1;
                    dev_c = 1'b1;
                    if (collide && k == 4) begin
                        bus.tx_data  = 8'h55;
                        bus.tx_valid = 1'b1;
                        repeat (3) @(negedge clk);
                        bus.tx_valid = 1'b0;
                        repeat (17) @(negedge clk);
                    end else begin
                        repeat (20) @(negedge clk);
                    end
                    dev_c = 1'b0;
                    repeat (2) @(negedge clk);
                    if (k <= 10) begin
                        frame[k] = ps2d_pin;
                        if (!bus.busy) busy_low++;
                    end
                    dev_d = 1'b0;
                    if (glitch && k >= 2 && k <= 9) begin
                        repeat (4) @(negedge clk);
                        dev_c = 1'b1;
                        repeat (2) @(negedge clk);
                        dev_c = 1'b0;
                        repeat (12) @(negedge clk);
                    end else begin
                        repeat (18) @(negedge clk);
                    end
                end
            end
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        int          stop_after;
        bit          nack;
        bit          glitch;
        bit          collide;
        bit          chk_frame;
        logic [10:0] frame;     // {stop, parity, data[7:0], start}
        int          exp_done;
        int          exp_err;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [10:0] frame;
        int busy_low, d0, e0, w, n;

        vecs[0] = '{8'hED, 11, 1'b0, 1'b0, 1'b0, 1'b1, 11'b11111011010, 1, 0, 2'd0};
        vecs[1] = '{8'h00, 11, 1'b0, 1'b0, 1'b0, 1'b1, 11'b11000000000, 1, 0, 2'd0};
        vecs[2] = '{8'h01, 11, 1'b0, 1'b0, 1'b0, 1'b1, 11'b10000000010, 1, 0, 2'd0};
        vecs[3] = '{8'hFF, 11, 1'b0, 1'b0, 1'b0, 1'b1, 11'b11111111110, 1, 0, 2'd0};
        vecs[4] = '{8'hED, 11, 1'b1, 1'b0, 1'b0, 1'b1, 11'b11111011010, 0, 1, 2'd3};
        vecs[5] = '{8'h3C,  5, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00000000000, 0, 1, 2'd2};
        vecs[6] = '{8'hA5, 11, 1'b0, 1'b1, 1'b0, 1'b1, 11'b11101001010, 1, 0, 2'd0};
        vecs[7] = '{8'hF0, 11, 1'b0, 1'b0, 1'b1, 1'b1, 11'b11111100000, 1, 0, 2'd0};

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
        chk("rst_err_code", {30'd0, bus.err_code}, 32'd0);
        chk("rst_lines", {30'd0, ps2c_low, ps2d_low}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send(vecs[i].data);
            dev_run(vecs[i].stop_after, vecs[i].nack, vecs[i].glitch, vecs[i].collide,
                    frame, busy_low);
            w = 0;
            while (done_cnt == d0 && err_cnt == e0 && w < 3000) begin
                @(negedge clk);
                w++;
            end
            repeat (5) @(negedge clk);
            if (vecs[i].chk_frame)
                chk($sformatf("frame_%0d", i), {21'd0, frame}, {21'd0, vecs[i].frame});
            chk($sformatf("done_pulses_%0d", i), done_cnt - d0, vecs[i].exp_done);
            chk($sformatf("err_pulses_%0d", i), err_cnt - e0, vecs[i].exp_err);
            chk($sformatf("err_code_%0d", i), {30'd0, bus.err_code}, {30'd0, vecs[i].code});
            chk($sformatf("busy_span_%0d", i), busy_low, 0);
            chk($sformatf("idle_after_%0d", i), {29'd0, bus.tx_ready, ps2c_low, ps2d_low}, 32'd4);
            repeat (10) @(negedge clk);
        end

        // Start timeout: device never clocks.
        e0 = err_cnt;
        send(8'h12);
        w = 0;
        while (!(!ps2c_low && ps2d_low) && w < 200) begin
            @(negedge clk);
            w++;
        end
        n = 0;
        while (!bus.err && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("start_timeout_cycles", n, 500);
        chk("start_timeout_code", {30'd0, bus.err_code}, 32'd1);
        chk("start_timeout_lines", {30'd0, ps2c_low, ps2d_low}, 32'd0);
        @(negedge clk);
        chk("start_timeout_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("start_timeout_pulses", err_cnt - e0, 1);
        repeat (10) @(negedge clk);

        // Reset asserted right after the sixth device falling edge.
        send(8'h00);
        dev_run(5, 1'b0, 1'b0, 1'b0, frame, busy_low);
        dev_c = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre_rst_d_low", {31'd0, ps2d_low}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_lines", {30'd0, ps2c_low, ps2d_low}, 32'd0);
        chk("rst_mid_ready", {31'd0, bus.tx_ready}, 32'd1);
        chk("rst_mid_code", {30'd0, bus.err_code}, 32'd0);
        dev_c = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hF4);
        dev_run(11, 1'b0, 1'b0, 1'b0, frame, busy_low);
        repeat (5) @(negedge clk);
        chk("post_rst_frame", {21'd0, frame}, {21'd0, 11'b10111101000});
        chk("post_rst_done", done_cnt - d0, 1);
        chk("post_rst_err", err_cnt - e0, 0);

        chk("done_err_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the opposite direction of the existing keyboard receiver.
- Sends one command byte per request to the keyboard, e.g. 0xED for LED set or 0xFF for reset.
- Follows the PS/2 request-to-send sequence and checks the device ACK.
- Drives the open-drain PS2C/PS2D pins through active-high pull-low enables. The top level builds the tristates.
- Asserts busy so the receiver ignores line activity while a transfer is in progress.

Parameters:
- INHIBIT_CYCLES, 2500: clock-low inhibit time in clk cycles (100 us at 25 MHz).
- REQ_CYCLES, 16: cycles with both lines held low before the clock is released.
- START_TIMEOUT, 375000: maximum wait for the first device falling edge (15 ms).
- XFER_TIMEOUT, 50000: maximum time from the first falling edge to the ACK edge (2 ms).
- FILTER_LEN, 4: number of consecutive equal synchronized samples needed to change the filtered PS2C level.

Ports:
- clk  in  1  system clock; the same domain as kbd0 (clkdiv[1]).
- rst  in  1  asynchronous, active-high reset.
- PS2C  in  1  raw PS/2 clock pin level.
- PS2D  in  1  raw PS/2 data pin level.
- tx_data  in  8  command byte to send.
- tx_valid  in  1  send request; accepted only when tx_ready=1.
- tx_ready  out  1  high in IDLE only.
- ps2c_low  out  1  1 = pull PS2C low; 0 = release.
- ps2d_low  out  1  1 = pull PS2D low; 0 = release.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a transfer completes with ACK.
- err  out  1  one-cycle pulse when a transfer is aborted.
- err_code  out  2  cause of the last abort: 0 none, 1 start timeout, 2 transfer timeout, 3 no ACK. Holds until the next accept.

Behaviour:

Input conditioning:
- PS2C and PS2D each pass through a 2-flop synchronizer.
- The filtered clock level changes only after FILTER_LEN consecutive equal synchronized samples.
- fall = one-cycle strobe on a filtered 1->0 transition.

Reset (asynchronous):
- All outputs 0 except tx_ready=1. err_code=0, state=IDLE.
- Lines are released immediately on reset, including mid-transfer.

State machine:
- IDLE: on tx_valid&tx_ready:
  - latch shift[8:0] = {~^tx_data, tx_data}, giving odd parity;
  - clear err_code; go to INHIBIT.
  - tx_ready falls the next cycle.
- INHIBIT: ps2c_low=1, ps2d_low=0 for INHIBIT_CYCLES cycles, then go to REQ.
- REQ: ps2c_low=1, ps2d_low=1 for REQ_CYCLES cycles, then go to WAIT_CLK.
- WAIT_CLK:
  - ps2c_low=0, ps2d_low=1 (start bit).
  - Timer counts from entry. If START_TIMEOUT is reached with no fall, abort with code 1.
  - On fall: ps2d_low <= ~shift[0], shift >>= 1, edge_cnt=1, XFER timer restarts; go to SHIFT.
- SHIFT (each fall increments edge_cnt):
  - edges 2..9: ps2d_low <= ~shift[0], shift >>= 1. This covers data bits 1..7 and then parity; bit 0 was driven on edge 1.
  - edge 10: ps2d_low <= 0 (stop bit = released line).
  - edge 11: sample the synchronized PS2D. 0 goes to WAIT_IDLE; 1 aborts with code 3.
  - The XFER timer reaching XFER_TIMEOUT before edge 11 aborts with code 2.
- WAIT_IDLE:
  - Wait for filtered PS2C high. The XFER timer still applies (code 2).
  - Then pulse done=1 for one cycle and return to IDLE.
- Abort:
  - ps2c_low=ps2d_low=0 in the same cycle the abort is detected.
  - err=1 for one cycle, err_code latched, then IDLE.

Boundary conditions:
- tx_valid while busy is ignored; no queueing. The requester must hold tx_valid until it sees tx_ready.
- A fall seen in IDLE, INHIBIT or REQ is ignored; the device is inhibited in those states.
- done and err are never high together. At most one of them pulses per accepted request.
- Timers saturate and must not wrap. Counter widths are sized to hold the parameter values.
- ps2c_low and ps2d_low are registered outputs; no combinational path from the inputs.

Test Plan (bench uses INHIBIT_CYCLES=20, REQ_CYCLES=4, START_TIMEOUT=500, XFER_TIMEOUT=2000, FILTER_LEN=4, plus a device model clocking at a 40-cycle period):
- Send 0xED -> PS2D levels sampled on device rising edges are 0 (start), then 1,0,1,1,0,1,1,1, parity 1, stop 1. Model ACKs; done pulses once, err=0, busy spans the whole transfer.
- Parity/edge values: send 0x00 -> parity 1; send 0x01 -> parity 0; send 0xFF -> parity 1. All complete with done.
- Start timeout: device never clocks -> err pulses with err_code=1 exactly 500 cycles after WAIT_CLK entry. Both lines released; tx_ready=1 the next cycle.
- No ACK: model holds PS2D high on edge 11 -> err with err_code=3 and no done. A transfer timeout case (model stops after edge 5) -> err_code=2.
- Reset mid-transfer: assert rst at edge 6 -> ps2c_low=ps2d_low=0 asynchronously, tx_ready=1, err_code=0. A new 0xF4 after reset completes normally.
- Glitches/collisions:
  - 2-cycle low glitches on PS2C during SHIFT -> edge_cnt unchanged, and the transmitted byte is still correct.
  - tx_valid pulsed with 0x55 during busy -> ignored; only the original byte is sent.
